hist_peak_finder: RTL and testbench

- Sits directly downstream of the histogram builder FSM and consumes its per-pixel bin-count stream during histogram readout.
- For each pixel histogram it finds the bin with the largest count and emits one peak record: pixel index, peak bin address and peak count.
- Its output feeds the algebraic block, which derives the threshold/delta window for the fine-histogram pass.

---
 rtl/hist_peak_finder_pkg.sv | 15 +
 rtl/hist_peak_cmp.sv | 21 ++
 rtl/hist_peak_finder.sv | 124 ++++++++++++
 tb/tb_hist_peak_finder.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/hist_peak_finder_pkg.sv
// Shared defaults and FSM encoding for the histogram peak finder.
// Optional build macro used by this block: PEAK_THRESH_EN.
package hist_peak_finder_pkg;

  localparam int NB_DEF     = 5;  // Nb: bin address width
  localparam int CW_DEF     = 8;  // peakMax: bin count width
  localparam int PIXELS_DEF = 3;  // PIXEL_NUM_PER_RAM
  localparam int PW_DEF     = 2;  // pixel index width, 2**PW >= PIXELS

  typedef enum logic {
    SCAN = 1'b0,
    HOLD = 1'b1
  } state_e;

endpackage

// File: rtl/hist_peak_cmp.sv
// Running-maximum select: picks the incoming bin or keeps the stored peak.
// The first bin of a pixel always loads; ties keep the lower (stored) address.
module hist_peak_cmp #(
  parameter int NB = 5,
  parameter int CW = 8
) (
  input  logic [CW-1:0] bin_count,
  input  logic [NB-1:0] bin_addr,
  input  logic [CW-1:0] max_cnt,
  input  logic [NB-1:0] max_addr,
  output logic [CW-1:0] sel_cnt,
  output logic [NB-1:0] sel_addr
);

  logic take;

  assign take     = (bin_addr == '0) || (bin_count > max_cnt);
  assign sel_cnt  = take ? bin_count : max_cnt;
  assign sel_addr = take ? bin_addr  : max_addr;

endmodule

// File: rtl/hist_peak_finder.sv
// Per-pixel histogram peak finder: scans a bin-count stream, emits one peak record per pixel.
// Optional build macro: PEAK_THRESH_EN adds peak_thresh input and no_peak output.
module hist_peak_finder
  import hist_peak_finder_pkg::*;
#(
  parameter int NB     = NB_DEF,
  parameter int CW     = CW_DEF,
  parameter int PIXELS = PIXELS_DEF,
  parameter int PW     = PW_DEF
) (
  input  logic          clk,
  input  logic          res,
  input  logic          bin_valid,
  output logic          bin_ready,
  input  logic [CW-1:0] bin_count,
  input  logic          bin_last,
  output logic          peak_valid,
  input  logic          peak_ready,
  output logic [PW-1:0] peak_pixel,
  output logic [NB-1:0] peak_bin,
  output logic [CW-1:0] peak_count,
  output logic          len_err,
  output logic          frame_done,
`ifdef PEAK_THRESH_EN
  input  logic [CW-1:0] peak_thresh,
  output logic          no_peak,
`endif
  output state_e        dbg_state
);

  // Handshake: a bin moves on bin_valid && bin_ready, a record on peak_valid && peak_ready;
  // peak_* are held constant from peak_valid rising until the record is taken.

  state_e        state, state_nxt;
  logic          ready_en;
  logic [NB-1:0] bin_addr;
  logic [PW-1:0] pix_idx;
  logic [CW-1:0] max_cnt;
  logic [NB-1:0] max_addr;
  logic [CW-1:0] sel_cnt;
  logic [NB-1:0] sel_addr;
  logic          addr_top;
  logic          bin_fire;
  logic          peak_fire;

  assign addr_top  = (bin_addr == {NB{1'b1}});
  assign bin_fire  = bin_valid && bin_ready;
  assign peak_fire = peak_valid && peak_ready;
  assign dbg_state = state;

  hist_peak_cmp #(.NB(NB), .CW(CW)) u_cmp (
    .bin_count (bin_count),
    .bin_addr  (bin_addr),
    .max_cnt   (max_cnt),
    .max_addr  (max_addr),
    .sel_cnt   (sel_cnt),
    .sel_addr  (sel_addr)
  );

  always_ff @(posedge clk or negedge res) begin
    if (!res) state <= SCAN;
    else      state <= state_nxt;
  end

  // ready_en holds bin_ready low for the first cycle out of reset.
  always_comb begin
    state_nxt  = state;
    bin_ready  = 1'b0;
    peak_valid = 1'b0;
    case (state)
      SCAN: begin
        bin_ready = ready_en;
        if (ready_en && bin_valid && (bin_last || addr_top)) state_nxt = HOLD;
      end
      HOLD: begin
        peak_valid = 1'b1;
        if (peak_ready) state_nxt = SCAN;
      end
      default: state_nxt = SCAN;
    endcase
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      ready_en   <= 1'b0;
      bin_addr   <= '0;
      pix_idx    <= '0;
      max_cnt    <= '0;
      max_addr   <= '0;
      peak_pixel <= '0;
      peak_bin   <= '0;
      peak_count <= '0;
      len_err    <= 1'b0;
      frame_done <= 1'b0;
`ifdef PEAK_THRESH_EN
      no_peak    <= 1'b0;
`endif
    end else begin
      ready_en   <= 1'b1;
      frame_done <= 1'b0;
      if (bin_fire) begin
        max_cnt  <= sel_cnt;
        max_addr <= sel_addr;
        bin_addr <= bin_addr + NB'(1);
        if (bin_last || addr_top) begin
          // The closing bin is already folded into sel_*, so the record is final here.
          peak_pixel <= pix_idx;
          peak_bin   <= sel_addr;
          peak_count <= sel_cnt;
          if (addr_top && !bin_last) len_err <= 1'b1;
`ifdef PEAK_THRESH_EN
          no_peak    <= (sel_cnt < peak_thresh);
`endif
        end
      end
      if (peak_fire) begin
        bin_addr   <= '0;
        pix_idx    <= (pix_idx == PW'(PIXELS - 1)) ? '0 : pix_idx + PW'(1);
        frame_done <= (peak_pixel == PW'(PIXELS - 1));
      end
    end
  end

endmodule

// File: tb/tb_hist_peak_finder.sv
// Directed table-driven bench for hist_peak_finder at NB=3, CW=8, PIXELS=3.
// Optional build macro: PEAK_THRESH_EN enables the no_peak checks.
module tb_hist_peak_finder;
  import hist_peak_finder_pkg::*;

  localparam int NB = 3;
  localparam int CW = 8;
  localparam int PIXELS = 3;
  localparam int PW = 2;
  localparam int RW = PW + NB + CW;

  logic          clk;
  logic          res;
  logic          bin_valid;
  logic          bin_ready;
  logic [CW-1:0] bin_count;
  logic          bin_last;
  logic          peak_valid;
  logic          peak_ready;
  logic [PW-1:0] peak_pixel;
  logic [NB-1:0] peak_bin;
  logic [CW-1:0] peak_count;
  logic          len_err;
  logic          frame_done;
  state_e        dbg_state;
`ifdef PEAK_THRESH_EN
  logic [CW-1:0] peak_thresh;
  logic          no_peak;
`endif

  int n_checks = 0;
  int n_pass = 0;
  logic [RW-1:0] exp_q[$];

  typedef struct {
    logic [7:0][CW-1:0] counts;
    int                 nbins;
    bit                 has_last;
    logic [PW-1:0]      exp_pixel;
    logic [NB-1:0]      exp_bin;
    logic [CW-1:0]      exp_count;
    bit                 exp_len_err;
    bit                 exp_frame;
    bit                 exp_no_peak;
  } vec_t;

  vec_t tbl[7];

  hist_peak_finder #(.NB(NB), .CW(CW), .PIXELS(PIXELS), .PW(PW)) dut (
    .clk        (clk),
    .res        (res),
    .bin_valid  (bin_valid),
    .bin_ready  (bin_ready),
    .bin_count  (bin_count),
    .bin_last   (bin_last),
    .peak_valid (peak_valid),
    .peak_ready (peak_ready),
    .peak_pixel (peak_pixel),
    .peak_bin   (peak_bin),
    .peak_count (peak_count),
    .len_err    (len_err),
    .frame_done (frame_done),
`ifdef PEAK_THRESH_EN
    .peak_thresh(peak_thresh),
    .no_peak    (no_peak),
`endif
    .dbg_state  (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  function automatic logic [7:0][CW-1:0] pack8(input int c0, c1, c2, c3, c4, c5, c6, c7);
    logic [7:0][CW-1:0] r;
    r[0] = CW'(c0); r[1] = CW'(c1); r[2] = CW'(c2); r[3] = CW'(c3);
    r[4] = CW'(c4); r[5] = CW'(c5); r[6] = CW'(c6); r[7] = CW'(c7);
    return r;
  endfunction

  // driver tasks (called at #1 after a rising edge)
  task automatic send_bin(input logic [CW-1:0] cnt, input logic last);
    int n;
    bin_valid = 1'b1;
    bin_count = cnt;
    bin_last  = last;
    n = 0;
    while (!bin_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n == 20) begin
      n_checks++;
      $display("FAIL bin_ready_timeout: got 0, expected 1 within 20 cycles");
    end
    @(posedge clk); #1;
  endtask

  task automatic send_hist(input logic [7:0][CW-1:0] c, input int nbins, input bit has_last);
    for (int i = 0; i < nbins; i++) send_bin(c[i], has_last && (i == nbins - 1));
    bin_valid = 1'b0;
    bin_last  = 1'b0;
    bin_count = '0;
  endtask

  task automatic check_record(input string tag, input bit exp_len, input bit exp_np);
    logic [RW-1:0] e;
    e = exp_q.pop_front();
    check({tag, "_valid"}, 32'(peak_valid), 32'd1);
    check({tag, "_pixel"}, 32'(peak_pixel), 32'(e[RW-1 -: PW]));
    check({tag, "_bin"},   32'(peak_bin),   32'(e[CW +: NB]));
    check({tag, "_count"}, 32'(peak_count), 32'(e[CW-1:0]));
    check({tag, "_len_err"}, 32'(len_err), 32'(exp_len));
`ifdef PEAK_THRESH_EN
    check({tag, "_no_peak"}, 32'(no_peak), 32'(exp_np));
`else
    if (exp_np) begin end
`endif
  endtask

  task automatic accept(input string tag, input bit exp_frame);
    peak_ready = 1'b1;
    @(posedge clk); #1;
    peak_ready = 1'b0;
    check({tag, "_frame_done"}, 32'(frame_done), 32'(exp_frame));
    check({tag, "_released"}, 32'({peak_valid, bin_ready}), 32'b01);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_bin_ready"},  32'(bin_ready), 32'd0);
    check({tag, "_peak_valid"}, 32'(peak_valid), 32'd0);
    check({tag, "_peak_fields"}, 32'({peak_pixel, peak_bin, peak_count}), 32'd0);
    check({tag, "_len_err"},    32'(len_err), 32'd0);
    check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
  endtask

  initial begin
    logic [PW-1:0] hp;
    logic [NB-1:0] hb;
    logic [CW-1:0] hc;

    tbl[0] = '{pack8(20,3,3,19,0,1,2,20),  8, 1'b1, 2'd1, 3'd0, 8'd20, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{pack8(1,2,3,12,12,0,5,6),   8, 1'b1, 2'd2, 3'd3, 8'd12, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{pack8(0,0,5,1,0,0,0,0),     4, 1'b1, 2'd0, 3'd2, 8'd5,  1'b0, 1'b0, 1'b1};
    tbl[3] = '{pack8(0,0,0,0,0,0,0,0),     2, 1'b1, 2'd1, 3'd0, 8'd0,  1'b0, 1'b0, 1'b1};
    tbl[4] = '{pack8(4,4,4,4,4,4,30,4),    8, 1'b1, 2'd2, 3'd6, 8'd30, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{pack8(9,1,1,1,1,1,1,11),    8, 1'b0, 2'd0, 3'd7, 8'd11, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{pack8(2,3,0,0,0,0,0,0),     2, 1'b1, 2'd1, 3'd1, 8'd3,  1'b1, 1'b0, 1'b1};

    res = 1'b0;
    bin_valid = 1'b0;
    bin_count = '0;
    bin_last = 1'b0;
    peak_ready = 1'b0;
`ifdef PEAK_THRESH_EN
    peak_thresh = 8'd10;
`endif
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    check("reset_state", 32'(dbg_state), 32'(SCAN));
    @(negedge clk);
    res = 1'b1;
    @(posedge clk); #1;
    check("ready_after_reset", 32'(bin_ready), 32'd1);

    // first pixel: tie at 9 keeps bin 2, record visible one cycle after the last bin
    exp_q.push_back({2'd0, 3'd2, 8'd9});
    send_hist(pack8(1,4,9,9,2,0,0,7), 8, 1'b1);
    check_record("px0", 1'b0, 1'b1);
    hp = peak_pixel; hb = peak_bin; hc = peak_count;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("hold_bin_ready", 32'(bin_ready), 32'd0);
      check("hold_stable", 32'({peak_valid, peak_pixel, peak_bin, peak_count}), 32'({1'b1, hp, hb, hc}));
    end
    accept("px0", 1'b0);

    // table: back-to-back pixels, pixel wrap, short/all-zero histograms, missing bin_last
    for (int t = 0; t < 7; t++) begin
      string tag;
      tag = $sformatf("vec%0d", t);
      exp_q.push_back({tbl[t].exp_pixel, tbl[t].exp_bin, tbl[t].exp_count});
      send_hist(tbl[t].counts, tbl[t].nbins, tbl[t].has_last);
      check_record(tag, tbl[t].exp_len_err, tbl[t].exp_no_peak);
      accept(tag, tbl[t].exp_frame);
      if (tbl[t].exp_frame) begin
        @(posedge clk); #1;
        check({tag, "_frame_pulse_end"}, 32'(frame_done), 32'd0);
      end
    end

    // reset in the middle of a pixel
    bin_valid = 1'b1; bin_count = 8'd50; bin_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    res = 1'b0;
    #1;
    check_reset_outputs("midscan_reset");
    bin_valid = 1'b0;
    @(negedge clk);
    res = 1'b1;
    @(posedge clk); #1;
    exp_q.push_back({2'd0, 3'd1, 8'd8});
    send_hist(pack8(3,8,0,0,0,0,0,0), 2, 1'b1);
    check_record("post_reset", 1'b0, 1'b1);
    accept("post_reset", 1'b0);

    // above-threshold maximum
    exp_q.push_back({2'd1, 3'd4, 8'd12});
    send_hist(pack8(1,1,1,1,12,1,1,1), 8, 1'b1);
    check_record("thresh12", 1'b0, 1'b0);
    accept("thresh12", 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
